// File: rtl/exec_pkg.sv
// Shared types for the execute/writeback stage: opcodes, FSM states and
// default sizing. Opcodes 5..7 have no enum member and decode as NOP.
package exec_pkg;

   localparam int DEFAULT_REG_COUNT = 16;
   localparam int DEFAULT_DATA_BITS = 8;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_CMP  = 3'd2,
      OP_MOV  = 3'd3,
      OP_MOVI = 3'd4
   } exec_op_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_OPERAND   = 2'd1,
      ST_EXECUTE   = 2'd2,
      ST_WRITEBACK = 2'd3
   } exec_state_e;

   // Ops whose result lands in R[rd].
   function automatic logic op_writes_rd(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MOV) || (op == OP_MOVI);
   endfunction

   // Ops that drive the ALU and take their carry from it.
   function automatic logic op_uses_alu(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) || (op == OP_MOV);
   endfunction

endpackage

// File: rtl/reg_file.sv
// General register file: two combinational operand read ports, one
// combinational debug read port, one synchronous write port and an
// asynchronous active-low clear of every entry.
module reg_file
   import exec_pkg::*;
#(
   parameter  int DATA_BITS = DEFAULT_DATA_BITS,
   parameter  int REG_COUNT = DEFAULT_REG_COUNT,
   localparam int REG_BITS  = $clog2(REG_COUNT)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 we_i,
   input  logic [REG_BITS-1:0]  waddr_i,
   input  logic [DATA_BITS-1:0] wdata_i,
   input  logic [REG_BITS-1:0]  rs_addr_i,
   output logic [DATA_BITS-1:0] rs_data_o,
   input  logic [REG_BITS-1:0]  rt_addr_i,
   output logic [DATA_BITS-1:0] rt_data_o,
   input  logic [REG_BITS-1:0]  dbg_addr_i,
   output logic [DATA_BITS-1:0] dbg_data_o
);

   logic [DATA_BITS-1:0] mem_q [REG_COUNT];

   // Storage: cleared on reset, single write per cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rs_data_o  = mem_q[rs_addr_i];
   assign rt_data_o  = mem_q[rt_addr_i];
   assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_unit.sv
// Execute/writeback stage around an external combinational ALU.
// One instruction every four cycles: IDLE -> OPERAND -> EXECUTE -> WRITEBACK.
// Optional macro EXEC_SIGNED_FLAGS_EN adds the neg/overflow flag logic;
// without it ovf_flag and neg_flag are constant 0.
//
// Handshake: an instruction is taken on a rising edge where in_valid and
// in_ready are both 1; in_ready is 1 only in IDLE, and upstream keeps
// in_valid and the instruction fields stable until that edge.
module alu_exec_unit
   import exec_pkg::*;
#(
   parameter  int DATA_BITS = DEFAULT_DATA_BITS,
   parameter  int REG_COUNT = DEFAULT_REG_COUNT,
   localparam int REG_BITS  = $clog2(REG_COUNT)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_op,
   input  logic [REG_BITS-1:0]  in_rd,
   input  logic [REG_BITS-1:0]  in_rs,
   input  logic [REG_BITS-1:0]  in_rt,
   input  logic [DATA_BITS-1:0] in_imm,
   output logic [DATA_BITS-1:0] alu_a,
   output logic [DATA_BITS-1:0] alu_b,
   output logic                 alu_cin,
   input  logic [DATA_BITS-1:0] alu_result,
   input  logic                 alu_cout,
   output logic                 zero_flag,
   output logic                 carry_flag,
   output logic                 ovf_flag,
   output logic                 neg_flag,
   output logic                 done,
   input  logic [REG_BITS-1:0]  dbg_addr,
   output logic [DATA_BITS-1:0] dbg_data
);

   localparam int MSB = DATA_BITS - 1;

   exec_state_e state_q, state_d;

   logic                 in_ready_c;
   logic                 load_ops;
   logic                 capture;
   logic                 retire;

   logic [2:0]           op_q;
   logic [REG_BITS-1:0]  rd_q, rs_q, rt_q;
   logic [DATA_BITS-1:0] imm_q;

   logic [DATA_BITS-1:0] alu_a_q, alu_b_q;
   logic                 alu_cin_q;
   logic [DATA_BITS-1:0] res_q;
   logic                 cout_q;

   logic                 zero_q, carry_q, done_q;
   logic                 rf_we;
   logic [DATA_BITS-1:0] rs_data, rt_data;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state strobes.
   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      load_ops   = 1'b0;
      capture    = 1'b0;
      retire     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
               state_d = ST_OPERAND;
            end
         end
         ST_OPERAND: begin
            load_ops = 1'b1;
            state_d  = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            capture = 1'b1;
            state_d = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            retire  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_ready = in_ready_c;

   // Instruction latch, loaded on the accepting edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q  <= '0;
         rd_q  <= '0;
         rs_q  <= '0;
         rt_q  <= '0;
         imm_q <= '0;
      end else if (in_valid && in_ready_c) begin
         op_q  <= in_op;
         rd_q  <= in_rd;
         rs_q  <= in_rs;
         rt_q  <= in_rt;
         imm_q <= in_imm;
      end
   end

   // ALU operand registers; MOVI and NOP leave them untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_cin_q <= 1'b0;
      end else if (load_ops) begin
         case (op_q)
            OP_ADD: begin
               alu_a_q   <= rs_data;
               alu_b_q   <= rt_data;
               alu_cin_q <= 1'b0;
            end
            OP_SUB, OP_CMP: begin
               alu_a_q   <= rs_data;
               alu_b_q   <= rt_data;
               alu_cin_q <= 1'b1;
            end
            OP_MOV: begin
               alu_a_q   <= rs_data;
               alu_b_q   <= '0;
               alu_cin_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Result capture; MOVI bypasses the ALU with its immediate.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_q  <= '0;
         cout_q <= 1'b0;
      end else if (capture) begin
         res_q  <= (op_q == OP_MOVI) ? imm_q : alu_result;
         cout_q <= alu_cout;
      end
   end

   // Architectural Z/C flags and the retire pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= retire;
         if (retire) begin
            if (op_uses_alu(op_q)) begin
               zero_q  <= (res_q == '0);
               carry_q <= cout_q;
            end else if (op_q == OP_MOVI) begin
               zero_q <= (res_q == '0);
            end
         end
      end
   end

   assign rf_we = retire && op_writes_rd(op_q);

   reg_file #(
      .DATA_BITS (DATA_BITS),
      .REG_COUNT (REG_COUNT)
   ) u_reg_file (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .we_i       (rf_we),
      .waddr_i    (rd_q),
      .wdata_i    (res_q),
      .rs_addr_i  (rs_q),
      .rs_data_o  (rs_data),
      .rt_addr_i  (rt_q),
      .rt_data_o  (rt_data),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

`ifdef EXEC_SIGNED_FLAGS_EN
   logic neg_q, ovf_q;
   logic eff_b_msb;

   // Subtracts feed the ALU ~b, so overflow is judged against that operand.
   assign eff_b_msb = alu_cin_q ? ~alu_b_q[MSB] : alu_b_q[MSB];

   // Signed flags: ALU ops update both, MOVI updates only the sign.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         neg_q <= 1'b0;
         ovf_q <= 1'b0;
      end else if (retire) begin
         if (op_uses_alu(op_q)) begin
            neg_q <= res_q[MSB];
            ovf_q <= (alu_a_q[MSB] == eff_b_msb) && (res_q[MSB] != alu_a_q[MSB]);
         end else if (op_q == OP_MOVI) begin
            neg_q <= res_q[MSB];
         end
      end
   end

   assign neg_flag = neg_q;
   assign ovf_flag = ovf_q;
`else
   assign neg_flag = 1'b0;
   assign ovf_flag = 1'b0;
`endif

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign zero_flag  = zero_q;
   assign carry_flag = carry_q;
   assign done       = done_q;

endmodule
